clock_time_controller: RTL and testbench
========================================

Name: clock_time_controller

Overview:
- Sequences the 24-hour timekeeping datapath from the system clock.
- Generates the 1 s enable and runs the HH:MM:SS counters.
- Provides a button-driven time-set state machine: set hours, then minutes.
- Produces the 16-bit HH:MM BCD word and per-digit blink mask for the 4-digit multiplexed 7-segment driver.

Parameters:
- TICK_DIV, 100000000, clk cycles per second; must be even and >= 4.
- HALF_DIV, TICK_DIV/2, cycles per blink half-period; derived, not overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_mode  input  1  one-cycle pulse, pre-synchronised/debounced; advances set mode
- btn_inc  input  1  one-cycle pulse, pre-synchronised/debounced; increments selected field
- tick_1s  output  1  one-cycle pulse per second
- seconds  output  6  0..59
- minutes  output  6  0..59
- hours  output  5  0..23
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
- bcd_data  output  16  {hr_tens, hr_ones, min_tens, min_ones}, 4 bits each
- blank_mask  output  4  1 = blank digit; bit3 = hr_tens ... bit0 = min_ones

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM = RUN, prescaler = 0, blink_phase = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; runs in all modes.
  - tick_1s = 1 exactly in the cycle the count equals TICK_DIV-1.
  - blink_phase toggles when the count equals HALF_DIV-1 or TICK_DIV-1.
- RUN (tick_1s=1):
  - seconds +1; 59 wraps to 0 and carries into minutes.
  - minutes 59 wraps to 0 and carries into hours.
  - hours 23 wraps to 0.
  - All updates land in the same clk edge. 23:59:59 -> 00:00:00.
- FSM transitions on btn_mode: RUN -> SET_HR -> SET_MIN -> RUN.
- SET_HR / SET_MIN:
  - Time counters frozen; tick_1s still pulses but is ignored.
  - btn_inc increments the selected field with wrap (hours 23->0, minutes 59->0).
  - No carry in either direction; seconds untouched.
- Exit SET_MIN -> RUN: seconds and prescaler cleared in the same edge, so the first tick arrives TICK_DIV cycles later.
- btn_inc in RUN is ignored.
- btn_mode and btn_inc in the same cycle: mode transition taken, inc ignored.
- tick_1s coincident with btn_mode in RUN: the tick increments time in the same edge that enters SET_HR.
- bcd_data:
  - Registered from hours/minutes; lags them by 1 cycle.
  - Tens = value/10, ones = value%10; hr_tens is in 0..2, min_tens in 0..5.
  - Upper bits of each nibble are 0.
- blank_mask: combinational from FSM and blink_phase.
  - RUN: 0000.
  - SET_HR: {blink_phase, blink_phase, 0, 0}.
  - SET_MIN: {0, 0, blink_phase, blink_phase}.
- Reset mid-set: returns to RUN with time 00:00:00 immediately (async).
- Illegal mode encoding 11 recovers to RUN on the next clk.

Decomposition:
- Shared package holds:
  - mode encodings MODE_RUN/MODE_SET_HR/MODE_SET_MIN
  - limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23
  - widths SEC_W=6, MIN_W=6, HR_W=5
- One sub-module, bin2bcd_2digit: combinational 6-bit (0..59) to two BCD nibbles via compare/subtract chain.
  - Instantiated twice (hours, minutes).

Test Plan:
- TICK_DIV=10, release reset, run 100 cycles -> tick_1s pulses at cycles 9,19,...; seconds=10; bcd_data=16'h0000.
- Preload via set mode 23:59, exit to RUN, run 60 ticks -> after the 60th tick time 00:00:00, bcd_data=16'h0000 one cycle later.
- btn_mode once, btn_inc x25 -> mode=01, hours=1 (23->0 wrap then +1); minutes/seconds unchanged; blank_mask toggles 1100/0000 every 5 cycles.
- btn_mode, btn_mode, btn_inc x61, btn_mode -> minutes=1, hours unchanged, mode=00, seconds=0; next tick exactly 10 cycles after exit.
- btn_mode and btn_inc asserted together in SET_HR -> mode=10, hours unchanged.
- Assert reset=0 mid SET_MIN at 12:34 -> outputs all 0, mode=00 without waiting for clk; after release, counting restarts from 00:00:00.

Source files
------------

// File: rtl/clock_time_controller_pkg.sv
// Shared encodings, field widths and limits for the 24-hour clock controller.
package clock_time_controller_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

endpackage

// File: rtl/clock_time_controller_bin2bcd_2digit.sv
// Combinational 0..59 binary to two BCD digits using a compare/subtract chain.
module bin2bcd_2digit (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] rem;

  always_comb begin
    tens = 4'd0;
    rem  = bin;
    if (bin >= 6'd50) begin
      tens = 4'd5;
      rem  = bin - 6'd50;
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      rem  = bin - 6'd40;
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      rem  = bin - 6'd30;
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      rem  = bin - 6'd20;
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      rem  = bin - 6'd10;
    end
    ones = 4'(rem);
  end

endmodule

// File: rtl/clock_time_controller.sv
// 24-hour HH:MM:SS timekeeper with 1 s prescaler, button-driven time set and
// BCD/blink outputs for a 4-digit multiplexed 7-segment display.
module clock_time_controller
  import clock_time_controller_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic             tick_1s,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [1:0]       mode,
  output logic [15:0]      bcd_data,
  output logic [3:0]       blank_mask
);

  localparam int HALF_DIV = TICK_DIV / 2;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF_DIV - 1);

  mode_e         state;
  logic [PW-1:0] presc;
  logic          blink_phase;
  logic          set_exit;
  logic          sec_wrap, min_wrap, hr_wrap;
  logic [3:0]    hr_tens, hr_ones, min_tens, min_ones;
  logic [15:0]   bcd_p1;

  assign tick_1s  = (presc == TICK_LAST);
  assign set_exit = (state == MODE_SET_MIN) && btn_mode;
  assign sec_wrap = (seconds == SEC_MAX);
  assign min_wrap = (minutes == MIN_MAX);
  assign hr_wrap  = (hours == HR_MAX);
  assign mode     = state;

  // Prescaler restarts on leaving set mode so the first second is a full one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (set_exit || tick_1s) presc <= '0;
      else                     presc <= presc + PW'(1);
      if (presc == HALF_LAST || presc == TICK_LAST) blink_phase <= ~blink_phase;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= MODE_RUN;
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else begin
      case (state)
        MODE_RUN: begin
          if (tick_1s) begin
            seconds <= sec_wrap ? '0 : seconds + SEC_W'(1);
            if (sec_wrap) minutes <= min_wrap ? '0 : minutes + MIN_W'(1);
            if (sec_wrap && min_wrap) hours <= hr_wrap ? '0 : hours + HR_W'(1);
          end
          if (btn_mode) state <= MODE_SET_HR;
        end
        MODE_SET_HR: begin
          if (btn_mode)     state <= MODE_SET_MIN;
          else if (btn_inc) hours <= hr_wrap ? '0 : hours + HR_W'(1);
        end
        MODE_SET_MIN: begin
          if (btn_mode) begin
            state   <= MODE_RUN;
            seconds <= '0;
          end else if (btn_inc) begin
            minutes <= min_wrap ? '0 : minutes + MIN_W'(1);
          end
        end
        default: state <= MODE_RUN;
      endcase
    end
  end

  bin2bcd_2digit u_hr_bcd (
    .bin  ({1'b0, hours}),
    .tens (hr_tens),
    .ones (hr_ones)
  );

  bin2bcd_2digit u_min_bcd (
    .bin  (minutes),
    .tens (min_tens),
    .ones (min_ones)
  );

  // Display word stage: one cycle behind the time counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bcd_p1 <= '0;
    else        bcd_p1 <= {hr_tens, hr_ones, min_tens, min_ones};
  end

  assign bcd_data = bcd_p1;

  always_comb begin
    blank_mask = 4'b0000;
    case (state)
      MODE_SET_HR:  blank_mask = {blink_phase, blink_phase, 2'b00};
      MODE_SET_MIN: blank_mask = {2'b00, blink_phase, blink_phase};
      default:      blank_mask = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with TICK_DIV=10.
module tb_clock_time_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        tick_1s;
  logic [5:0]  seconds;
  logic [5:0]  minutes;
  logic [4:0]  hours;
  logic [1:0]  mode;
  logic [15:0] bcd_data;
  logic [3:0]  blank_mask;

  int n_cmp = 0;
  int n_err = 0;

  clock_time_controller #(.TICK_DIV(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .tick_1s    (tick_1s),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .mode       (mode),
    .bcd_data   (bcd_data),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic       i;
    int         reps;
    logic [1:0] e_mode;
    int         e_hr;
    int         e_min;
    int         e_sec;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int mi, input int s);
    check({tag, "_hours"},   int'(hours),   h);
    check({tag, "_minutes"}, int'(minutes), mi);
    check({tag, "_seconds"}, int'(seconds), s);
  endtask

  initial begin
    int errs;
    int first;
    int changes;
    logic [3:0] s[21];

    tbl[0] = '{1'b1, 1'b0, 1,  2'b01, 0,  0,  10};
    tbl[1] = '{1'b0, 1'b1, 23, 2'b01, 23, 0,  10};
    tbl[2] = '{1'b1, 1'b0, 1,  2'b10, 23, 0,  10};
    tbl[3] = '{1'b0, 1'b1, 59, 2'b10, 23, 59, 10};
    tbl[4] = '{1'b1, 1'b0, 1,  2'b00, 23, 59, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", int'(tick_1s), 0);
    check_time("rst", 0, 0, 0);
    check("rst_mode", int'(mode), 0);
    check("rst_bcd", int'(bcd_data), 0);
    check("rst_blank", int'(blank_mask), 0);
    reset = 1'b1;

    // 100 cycles of free running: tick in cycles 9,19,...
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      if (tick_1s !== ((c % 10) == 9)) errs++;
      if (blank_mask !== 4'b0000) errs++;
      step(1'b0, 1'b0);
    end
    check("run_tick_pattern_errs", errs, 0);
    check_time("run100", 0, 0, 10);
    check("run100_bcd", int'(bcd_data), 16'h0000);

    // Preload 23:59 through the set modes
    for (int v = 0; v < 5; v++) begin
      repeat (tbl[v].reps) step(tbl[v].m, tbl[v].i);
      check($sformatf("tbl%0d_mode", v), int'(mode), int'(tbl[v].e_mode));
      check_time($sformatf("tbl%0d", v), tbl[v].e_hr, tbl[v].e_min, tbl[v].e_sec);
    end
    check("exit_bcd", int'(bcd_data), 16'h2359);

    // 60 ticks from 23:59:00 rolls over to 00:00:00
    first = -1;
    for (int k = 0; k < 600; k++) begin
      if (tick_1s && first < 0) first = k;
      if (k == 599) check_time("pre_roll", 23, 59, 59);
      step(1'b0, 1'b0);
    end
    check("exit_first_tick", first, 9);
    check_time("roll", 0, 0, 0);
    check("roll_bcd_lag", int'(bcd_data), 16'h2359);
    step(1'b0, 1'b0);
    check("roll_bcd", int'(bcd_data), 16'h0000);

    // SET_HR: 25 increments wrap 23->0 then land on 1
    step(1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b1);
    check("sethr_mode", int'(mode), 1);
    check_time("sethr", 1, 0, 0);

    // Blink in SET_HR: 1100/0000 with a toggle every 5 cycles
    for (int i = 0; i < 21; i++) begin
      s[i] = blank_mask;
      step(1'b0, 1'b0);
    end
    errs = 0;
    changes = 0;
    for (int i = 0; i < 21; i++)
      if (s[i] !== 4'b1100 && s[i] !== 4'b0000) errs++;
    for (int i = 0; i < 20; i++) if (s[i+1] !== s[i]) changes++;
    for (int i = 0; i < 16; i++) if (s[i+5] === s[i]) errs++;
    check("blink_shape_errs", errs, 0);
    check("blink_changes", changes, 4);

    // Mode and inc together: mode wins
    step(1'b1, 1'b1);
    check("both_mode", int'(mode), 2);
    check("both_hours", int'(hours), 1);
    repeat (61) step(1'b0, 1'b1);
    check_time("setmin", 1, 1, 0);
    step(1'b1, 1'b0);
    check("exit2_mode", int'(mode), 0);
    check_time("exit2", 1, 1, 0);

    // Inc ignored in RUN; first tick 10 cycles after exit coincides with btn_mode
    first = -1;
    for (int k = 0; k < 20; k++) begin
      if (tick_1s) begin
        first = k;
        step(1'b1, 1'b0);
        break;
      end
      step(1'b0, k == 0);
    end
    check("exit2_first_tick", first, 9);
    check("tickmode_mode", int'(mode), 1);
    check_time("tickmode", 1, 1, 1);

    // Set 12:34 then async reset mid SET_MIN
    repeat (11) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (33) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("set1234_mode", int'(mode), 2);
    check("set1234_bcd", int'(bcd_data), 16'h1234);
    reset = 1'b0;
    #2;
    check_time("async_rst", 0, 0, 0);
    check("async_rst_mode", int'(mode), 0);
    check("async_rst_bcd", int'(bcd_data), 0);
    check("async_rst_blank", int'(blank_mask), 0);
    check("async_rst_tick", int'(tick_1s), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) step(1'b0, 1'b0);
    check("restart_mode", int'(mode), 0);
    check_time("restart", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
